// File: rtl/csa_seq_pkg.sv
// Shared definitions for the carry-save frame-sum sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default lane/result widths, beat-length width, FSM state type.
package csa_seq_pkg;

  localparam int DW_DEF = 4;   // operand lane width
  localparam int RW_DEF = 10;  // result width; 15 beats * 4 lanes * 15 = 900 < 1024
  localparam int LEN_W  = 4;   // beats per frame, 0..15

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/csa_6to2_compressor.sv
// Combinational 6:2 carry-save reduction of {sum, carry, a, b, c, d}.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
// Ports: sum_i/carry_i (RW) running pair, a_i..d_i (DW) lanes,
//        sum_o/carry_o (RW) reduced pair. sum_o + carry_o == sum of inputs mod 2^RW.
module csa_6to2_compressor
  import csa_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] sum_i,
  input  logic [RW-1:0] carry_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  input  logic [DW-1:0] d_i,
  output logic [RW-1:0] sum_o,
  output logic [RW-1:0] carry_o
);

  // One 3:2 full-adder row; the carry vector is weighted one bit up.
  // Dropping the MSB carry is safe: the true frame sum never reaches 2^RW.
  function automatic logic [2*RW-1:0] csa3(input logic [RW-1:0] x,
                                           input logic [RW-1:0] y,
                                           input logic [RW-1:0] z);
    logic [RW-1:0] s;
    logic [RW-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [RW-1:0] a_x, b_x, c_x, d_x;
  logic [RW-1:0] s1, c1, s2, c2, s3, c3;

  assign a_x = {{(RW-DW){1'b0}}, a_i};
  assign b_x = {{(RW-DW){1'b0}}, b_i};
  assign c_x = {{(RW-DW){1'b0}}, c_i};
  assign d_x = {{(RW-DW){1'b0}}, d_i};

  // Two parallel rows reduce 6 -> 4, then two serial rows reduce 4 -> 3 -> 2.
  assign {c1, s1}         = csa3(sum_i, carry_i, a_x);
  assign {c2, s2}         = csa3(b_x, c_x, d_x);
  assign {c3, s3}         = csa3(s1, c1, s2);
  assign {carry_o, sum_o} = csa3(s3, c3, c2);

endmodule

// File: rtl/csa_sum_sequencer.sv
// Frame accumulator: sums len_i beats of four lanes in carry-save form, resolves once.
// Latency: result valid registered one edge after the last-beat edge (seen at the 2nd edge).
// Backpressure: op_ready_o only in ACCUM; result held in DONE until res_ready_i.
// Ports: clk_i, rst_n_i (async low), start_i/len_i frame request, a_i..d_i + op_valid_i/op_ready_o
//        beat channel, res_o/res_valid_o/res_ready_i result channel, busy_o.
// Option: define CSA_SEQ_STAT_EN to add frame_cnt_o (8-bit count of result handshakes).
module csa_sum_sequencer
  import csa_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  input  logic [DW-1:0]    c_i,
  input  logic [DW-1:0]    d_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  output logic [RW-1:0]    res_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
`ifdef CSA_SEQ_STAT_EN
  output logic [7:0]       frame_cnt_o,
`endif
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic [RW-1:0]    sum_q, sum_d;
  logic [RW-1:0]    carry_q, carry_d;
  logic [RW-1:0]    res_q, res_d;
  logic [RW-1:0]    csa_sum, csa_carry;

  csa_6to2_compressor #(.DW(DW), .RW(RW)) u_csa (
    .sum_i   (sum_q),
    .carry_i (carry_q),
    .a_i     (a_i),
    .b_i     (b_i),
    .c_i     (c_i),
    .d_i     (d_i),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );

  // Never wraps: the last beat is taken when cnt_q + 1 == len_q <= 15.
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    res_d       = res_q;
    op_ready_o  = 1'b0;
    res_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          cnt_d   = '0;
          sum_d   = '0;
          carry_d = '0;
          state_d = (len_i == '0) ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          sum_d   = csa_sum;
          carry_d = csa_carry;
          cnt_d   = cnt_inc;
          if (cnt_inc == len_q) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        // The only carry-propagate add in the datapath.
        res_d   = sum_q + carry_q;
        state_d = DONE;
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      res_q   <= res_d;
    end
  end

  assign res_o  = res_q;
  assign busy_o = (state_q != IDLE);

`ifdef CSA_SEQ_STAT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (res_valid_o && res_ready_i) frame_cnt_d = frame_cnt_q + 8'd1;  // wraps 255 -> 0
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: doc/csa_sum_sequencer.md
CSA_SUM_SEQUENCER -- requirements
Module: csa_sum_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk_i and rst_n_i.
REQ-002 Ports SHALL be, in order:
- clk_i  in  1  rising-edge clock
- rst_n_i  in  1  async active-low reset
- start_i  in  1  frame start request
- len_i  in  4  beats per frame, 0..15
- a_i, b_i, c_i, d_i  in  4 each  four operand lanes per beat
- op_valid_i  in  1  operand beat valid
- op_ready_o  out  1  operand beat ready
- res_o  out  10  frame sum
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted
- busy_o  out  1  frame in progress
REQ-003 Parameter DW SHALL default to 4 and set the operand lane width.
REQ-004 Parameter RW SHALL default to 10 and set the result width, sized so that 15 beats x 4 lanes x 15 = 900 fits.

Function
REQ-005 The FSM SHALL have four states: IDLE, ACCUM, RESOLVE and DONE.
REQ-006 In IDLE with start_i=1, the block SHALL latch len_i, clear the sum and carry vectors and the beat counter, and go to ACCUM if len_i!=0, or to RESOLVE if len_i==0.
REQ-007 start_i outside IDLE SHALL be ignored; it SHALL NOT relatch len_i or clear state.
REQ-008 op_ready_o SHALL be 1 only in ACCUM.
- A beat transfers when op_valid_i && op_ready_o.
REQ-009 Each transferred beat SHALL reduce {sum, carry, a_i, b_i, c_i, d_i} to new {sum, carry} by carry-save compression only, with no carry-propagate add in ACCUM.
REQ-010 Each transferred beat SHALL increment the beat counter; the transfer where counter+1 equals the latched len SHALL move the FSM to RESOLVE.
REQ-011 A cycle in ACCUM with op_valid_i=0 SHALL hold all state (stall).
REQ-012 RESOLVE SHALL last one cycle, register res_o = sum + carry (RW bits, no overflow possible) and go to DONE.
REQ-013 In DONE, res_valid_o SHALL be 1 and res_o SHALL be stable until res_ready_i=1; then the FSM SHALL go to IDLE.
- res_valid_o and res_ready_i both 1 in the same cycle -> IDLE next cycle.
- start_i in that same cycle is ignored.
REQ-014 res_valid_o SHALL first assert 2 cycles after the clock edge that accepted the last beat.
REQ-015 busy_o SHALL be 1 whenever the state is not IDLE.
REQ-016 res_o SHALL hold its last value in IDLE and ACCUM until the next RESOLVE.

Reset
REQ-017 On rst_n_i=0, the block SHALL go to IDLE immediately, independent of clk_i.
REQ-018 Reset SHALL clear the sum/carry vectors, beat counter, latched len and res_o to 0, and drive op_ready_o, res_valid_o and busy_o to 0.
REQ-019 Reset mid-frame (ACCUM/RESOLVE/DONE) SHALL discard the partial frame.
- No result is emitted.
- After deassertion the block waits for a new start_i.

Configuration
REQ-020 With macro CSA_SEQ_STAT_EN defined, the block SHALL add output frame_cnt_o (8 bits, reset 0).
- Increments by 1 on each result handshake (res_valid_o && res_ready_i).
- Wraps 255->0.
REQ-021 Without CSA_SEQ_STAT_EN, frame_cnt_o and its counter SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-022 Package csa_seq_pkg SHALL hold:
- DW and RW defaults;
- the 4-bit len width;
- the state enum typedef (IDLE, ACCUM, RESOLVE, DONE).
REQ-023 The 6:2 carry-save reduction SHALL be a combinational sub-module, csa_6to2_compressor.
- Inputs: sum, carry, four zero-extended lanes.
- Outputs: RW-bit sum and carry.
- The FSM, counters and registers stay in csa_sum_sequencer.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single beat: start, len=1, beat a..d = 15,15,15,15 -> res_o=60, res_valid_o 2 cycles after the beat edge.
- Max frame: len=15, all lanes 15 every beat -> res_o=900.
- Zero length: start with len=0 -> no op_ready_o, res_valid_o asserts with res_o=0.
- Backpressure and stall: len=3, beats (1,2,3,4), gap, (5,6,7,8), (0,0,0,1), res_ready_i low 5 cycles -> res_o=37 held stable; start_i pulsed during ACCUM and DONE has no effect.
- Mid-frame reset: reset after 2 of 4 beats -> all outputs 0; a new len=1 frame (1,1,1,1) -> res_o=4.
- With CSA_SEQ_STAT_EN: 257 back-to-back frames -> frame_cnt_o=1.
